// File: rtl/res_owner_arbiter_pkg.sv
// res_owner_arbiter_pkg
//   Shared definitions for the resource-ownership arbiter: FSM state
//   encoding, owner index width and (with ARB_STATS_EN) the grant
//   statistics counter width and saturation value.
//   No ports.

package res_owner_arbiter_pkg;

    // Owner index width is fixed so owner_id/timeout_owner keep the same
    // width for any NUM_REQ in 2..8.
    localparam int unsigned OWNER_W = 3;

    typedef enum logic [1:0] {
        ArbStIdle    = 2'd0,
        ArbStGranted = 2'd1,
        ArbStGap     = 2'd2
    } arb_state_e;

`ifdef ARB_STATS_EN
    localparam int unsigned     STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_SAT = '1;
`endif

endpackage

// File: rtl/res_owner_arbiter_rr_pick.sv
// res_owner_arbiter_rr_pick
//   Combinational round-robin picker. Searches req_i starting at start_i,
//   wrapping modulo NUM_REQ; the first set bit found wins.
//   Ports:
//     req_i     in  NUM_REQ  request vector
//     start_i   in  OWNER_W  index with highest priority (< NUM_REQ)
//     valid_o   out 1        at least one request present
//     winner_o  out OWNER_W  index of the winning requester

module res_owner_arbiter_rr_pick
    import res_owner_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] start_i,
    output logic               valid_o,
    output logic [OWNER_W-1:0] winner_o
);

    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] rot;
    int                 off;
    int                 sum;

    always_comb begin
        // Rotate so that bit 0 of rot corresponds to requester start_i.
        rot = NUM_REQ'({req_i, req_i} >> start_i);
        off = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot[i[SEL_W-1:0]]) begin
                off = i;
            end
        end
        sum = int'(start_i) + off;
        if (sum >= int'(NUM_REQ)) begin
            sum = sum - int'(NUM_REQ);
        end
        valid_o  = |req_i;
        winner_o = OWNER_W'(sum);
    end

endmodule

// File: rtl/res_owner_arbiter.sv
// res_owner_arbiter
//   Exclusive-ownership arbiter for one shared buffer. Level requests,
//   single-cycle release pulses, round-robin fairness, a one-cycle
//   turnaround gap after every ownership and a hold-time watchdog.
//   Optional feature macro: ARB_STATS_EN (per-requester grant counters).
//   Ports:
//     clk            in   clock
//     rst_n          in   asynchronous active-low reset
//     enable         in   low forces release and masks grant at once
//     req            in   level request per requester
//     rel            in   release pulse per requester (owner's bit only)
//     timeout_limit  in   max hold cycles, 0 disables the watchdog
//     grant          out  one-hot ownership, registered, ANDed with enable
//     busy           out  resource currently owned
//     owner_id       out  index of current/last owner
//     timeout_evt    out  one-cycle pulse on watchdog revoke
//     timeout_owner  out  index of last requester revoked (sticky)
//     stats_clr      in   (ARB_STATS_EN) synchronous counter clear
//     grant_cnt      out  (ARB_STATS_EN) 16-bit grant counts, req 0 in LSBs

module res_owner_arbiter
    import res_owner_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TMO_W      = 16,
    parameter int          INIT_OWNER = -1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    input  logic [TMO_W-1:0]   timeout_limit,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [OWNER_W-1:0] owner_id,
    output logic               timeout_evt,
    output logic [OWNER_W-1:0] timeout_owner
`ifdef ARB_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam bit                 INIT_GRANTED = (INIT_OWNER >= 0);
    localparam logic [OWNER_W-1:0] INIT_ID      = INIT_GRANTED ? OWNER_W'(INIT_OWNER) : '0;
    localparam logic [NUM_REQ-1:0] INIT_GRANT   =
        INIT_GRANTED ? (NUM_REQ'(1) << INIT_ID) : '0;
    localparam arb_state_e         INIT_STATE   = INIT_GRANTED ? ArbStGranted : ArbStIdle;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [TMO_W-1:0]   hold_q, hold_d;
    logic               tmo_evt_q, tmo_evt_d;
    logic [OWNER_W-1:0] tmo_owner_q, tmo_owner_d;

    logic [OWNER_W-1:0] start_idx;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_winner;
    logic               rel_own;
    logic               tmo_hit;

    // The last owner gets lowest priority: search begins just after it.
    assign start_idx = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    res_owner_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i    (req),
        .start_i  (start_idx),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    // grant_q is one-hot on the owner while GRANTED, so this selects rel[owner].
    assign rel_own = |(rel & grant_q);
    assign tmo_hit = (timeout_limit != '0) && (hold_q == timeout_limit - 1'b1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        tmo_evt_d   = 1'b0;
        tmo_owner_d = tmo_owner_q;
        if (!enable) begin
            state_d = ArbStIdle;
            grant_d = '0;
        end else begin
            case (state_q)
                ArbStIdle: begin
                    if (pick_valid) begin
                        state_d = ArbStGranted;
                        grant_d = NUM_REQ'(1) << pick_winner;
                        owner_d = pick_winner;
                        hold_d  = '0;
                    end
                end
                ArbStGranted: begin
                    if (rel_own) begin
                        // Release wins over a coincident watchdog expiry.
                        state_d = ArbStGap;
                        grant_d = '0;
                    end else if (tmo_hit) begin
                        state_d     = ArbStGap;
                        grant_d     = '0;
                        tmo_evt_d   = 1'b1;
                        tmo_owner_d = owner_q;
                    end else if (hold_q != '1) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ArbStGap: begin
                    state_d = ArbStIdle;
                    grant_d = '0;
                end
                default: begin
                    state_d = ArbStIdle;
                    grant_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_STATE;
            grant_q     <= INIT_GRANT;
            owner_q     <= INIT_ID;
            hold_q      <= '0;
            tmo_evt_q   <= 1'b0;
            tmo_owner_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            tmo_evt_q   <= tmo_evt_d;
            tmo_owner_q <= tmo_owner_d;
        end
    end

    assign grant         = grant_q & {NUM_REQ{enable}};
    assign busy          = (state_q == ArbStGranted);
    assign owner_id      = owner_q;
    assign timeout_evt   = tmo_evt_q;
    assign timeout_owner = tmo_owner_q;

`ifdef ARB_STATS_EN
    logic grant_evt;
    assign grant_evt = enable && (state_q == ArbStIdle) && pick_valid;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_stats
        logic [STAT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (stats_clr) begin
                cnt_d = '0;
            end else if (grant_evt && (pick_winner == OWNER_W'(g)) && (cnt_q != STAT_SAT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_res_owner_arbiter.sv
// tb_res_owner_arbiter
//   Directed self-checking bench for res_owner_arbiter with NUM_REQ=2,
//   TMO_W=16, INIT_OWNER=-1. Inputs change 1 ns after a rising edge and
//   outputs are checked at that point, so every check sees the state
//   registered by the preceding edge.

module tb_res_owner_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned TMO_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rel;
    logic [TMO_W-1:0]   timeout_limit;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic [2:0]         owner_id;
    logic               timeout_evt;
    logic [2:0]         timeout_owner;
`ifdef ARB_STATS_EN
    logic               stats_clr;
    logic [NUM_REQ*16-1:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] rr_seq [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [1:0] cur;

    always #5 clk = ~clk;

    res_owner_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .TMO_W      (TMO_W),
        .INIT_OWNER (-1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .req           (req),
        .rel           (rel),
        .timeout_limit (timeout_limit),
        .grant         (grant),
        .busy          (busy),
        .owner_id      (owner_id),
        .timeout_evt   (timeout_evt),
        .timeout_owner (timeout_owner)
`ifdef ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .grant_cnt     (grant_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b1;
        req           = '0;
        rel           = '0;
        timeout_limit = '0;
`ifdef ARB_STATS_EN
        stats_clr     = 1'b0;
`endif
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner_id), 32'h0);
        check("rst_tevt", 32'(timeout_evt), 32'h0);
        check("rst_towner", 32'(timeout_owner), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_grant", 32'(grant), 32'h0);

        // 1: single request, release, exact gap length.
        req = 2'b01;
        step();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_owner", 32'(owner_id), 32'h0);
        req = 2'b00;
        step();
        step();
        check("t1_hold", 32'(grant), 32'h1);
        rel = 2'b01;
        step();
        rel = 2'b00;
        check("t1_gap_grant", 32'(grant), 32'h0);
        check("t1_gap_busy", 32'(busy), 32'h0);
        req = 2'b01;  // ignored in GAP, picked up in IDLE
        step();
        check("t1_idle_grant", 32'(grant), 32'h0);
        step();
        check("t1_regrant", 32'(grant), 32'h1);

        // 2: both requesting, alternate with zero cycles between owners.
        req = 2'b11;
        cur = 2'b01;
        for (int k = 0; k < 4; k++) begin
            rel = cur;
            step();
            rel = 2'b00;
            check("t2_gap", 32'(grant), 32'h0);
            step();
            check("t2_idle", 32'(grant), 32'h0);
            step();
            check("t2_grant", 32'(grant), 32'(rr_seq[k]));
            cur = rr_seq[k];
        end

        // 3: watchdog revokes owner 1 after 8 granted cycles.
        timeout_limit = 16'd8;
        rel = 2'b01;
        req = 2'b10;
        step();
        rel = 2'b00;
        step();
        step();
        check("t3_grant1", 32'(grant), 32'h2);
        req = 2'b11;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t3_held", 32'(grant), 32'h2);
            check("t3_no_evt", 32'(timeout_evt), 32'h0);
        end
        step();
        check("t3_revoke", 32'(grant), 32'h0);
        check("t3_evt", 32'(timeout_evt), 32'h1);
        check("t3_towner", 32'(timeout_owner), 32'h1);
        check("t3_busy", 32'(busy), 32'h0);
        step();
        check("t3_evt_once", 32'(timeout_evt), 32'h0);
        check("t3_idle", 32'(grant), 32'h0);
        step();
        check("t3_next", 32'(grant), 32'h1);

        // 4: release on the 8th granted cycle is a normal release.
        for (int i = 0; i < 7; i++) begin
            step();
            check("t4_held", 32'(grant), 32'h1);
        end
        rel = 2'b01;
        step();
        rel = 2'b00;
        check("t4_rel", 32'(grant), 32'h0);
        check("t4_no_evt", 32'(timeout_evt), 32'h0);
        step();
        check("t4_no_evt2", 32'(timeout_evt), 32'h0);
        step();
        check("t4_next", 32'(grant), 32'h2);

        // 5: non-owner release ignored; enable masking and restart.
        timeout_limit = '0;
        rel = 2'b10;
        req = 2'b01;
        step();
        rel = 2'b00;
        step();
        step();
        check("t5_grant", 32'(grant), 32'h1);
        rel = 2'b10;
        step();
        rel = 2'b00;
        check("t5_foreign_rel", 32'(grant), 32'h1);
        check("t5_busy", 32'(busy), 32'h1);
        enable = 1'b0;
        #1;
        check("t5_mask_comb", 32'(grant), 32'h0);
        check("t5_busy_still", 32'(busy), 32'h1);
        step();
        check("t5_dis_busy", 32'(busy), 32'h0);
        step();
        check("t5_dis_grant", 32'(grant), 32'h0);
        check("t5_dis_owner", 32'(owner_id), 32'h0);
        check("t5_dis_tevt", 32'(timeout_evt), 32'h0);
        enable = 1'b1;
        step();
        check("t5_regrant", 32'(grant), 32'h1);
        check("t5_owner", 32'(owner_id), 32'h0);
        check("t5_towner_sticky", 32'(timeout_owner), 32'h1);

        // Asynchronous reset while owned.
        #2;
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_towner", 32'(timeout_owner), 32'h0);
        step();
        rst_n = 1'b1;

`ifdef ARB_STATS_EN
        // 6: grant statistics for requester 1, then clear.
        req = 2'b10;
        for (int n = 0; n < 5; n++) begin
            step();
            check("t6_grant", 32'(grant), 32'h2);
            rel = 2'b10;
            step();
            rel = 2'b00;
            if (n == 4) begin
                req = 2'b00;
            end
            step();
        end
        check("t6_cnt1", 32'(grant_cnt[31:16]), 32'd5);
        check("t6_cnt0", 32'(grant_cnt[15:0]), 32'd0);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("t6_clr", 32'(grant_cnt[31:16]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
